// File: rtl/vram_arbiter.sv
// Three-port VRAM arbiter: video owns even slots, CPU/blitter share the rest,
// with a starvation counter that forces a blitter grant. Reads return in 2 cycles.
module vram_arbiter #(
  parameter int unsigned AW         = 15,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic          vid_rvalid,
  output logic [7:0]    vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  output logic [7:0]    cpu_rdata,
  input  logic          blt_req,
  input  logic          blt_we,
  input  logic [AW-1:0] blt_addr,
  input  logic [7:0]    blt_wdata,
  output logic          blt_ack,
  output logic          blt_rvalid,
  output logic [7:0]    blt_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout,
  output logic [3:0]    starve_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_BLT  = 2'd3
  } own_e;

  logic          phase_q;
  own_e          gnt;
  own_e          rd_own_q, rd_own_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          vid_rvalid_q, cpu_rvalid_q, blt_rvalid_q;
  logic [DW-1:0] vid_rdata_q, cpu_rdata_q, blt_rdata_q;
  logic          blt_forced;

  assign blt_forced = blt_req && (32'(starve_q) >= STARVE_MAX);

  // Grant select; held off entirely while reset is asserted.
  always_comb begin
    gnt = OWN_NONE;
    if (reset_n) begin
      if (!phase_q && vid_req) gnt = OWN_VID;
      else if (blt_forced)     gnt = OWN_BLT;
      else if (cpu_req)        gnt = OWN_CPU;
      else if (blt_req)        gnt = OWN_BLT;
    end
  end

  // RAM port mux; address and data hold their last driven value when idle.
  always_comb begin
    ram_addr = addr_q;
    ram_din  = din_q;
    ram_we   = 1'b0;
    case (gnt)
      OWN_VID: ram_addr = vid_addr;
      OWN_CPU: begin
        ram_addr = cpu_addr;
        ram_din  = cpu_wdata;
        ram_we   = cpu_we;
      end
      OWN_BLT: begin
        ram_addr = blt_addr;
        ram_din  = blt_wdata;
        ram_we   = blt_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_own_d = ram_we ? OWN_NONE : gnt;
    starve_d = starve_q;
    if (!blt_req || gnt == OWN_BLT) starve_d = '0;
    else if (starve_q != CNT_SAT)   starve_d = starve_q + CW'(1);
  end

  assign vid_ack = (gnt == OWN_VID);
  assign cpu_ack = (gnt == OWN_CPU);
  assign blt_ack = (gnt == OWN_BLT);

  // rd_own_q marks the cycle ram_dout carries a read; capture it into the owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= 1'b0;
      rd_own_q     <= OWN_NONE;
      starve_q     <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      blt_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
      blt_rdata_q  <= '0;
    end else begin
      phase_q      <= ~phase_q;
      rd_own_q     <= rd_own_d;
      starve_q     <= starve_d;
      addr_q       <= ram_addr;
      din_q        <= ram_din;
      vid_rvalid_q <= (rd_own_q == OWN_VID);
      cpu_rvalid_q <= (rd_own_q == OWN_CPU);
      blt_rvalid_q <= (rd_own_q == OWN_BLT);
      if (rd_own_q == OWN_VID) vid_rdata_q <= ram_dout;
      if (rd_own_q == OWN_CPU) cpu_rdata_q <= ram_dout;
      if (rd_own_q == OWN_BLT) blt_rdata_q <= ram_dout;
    end
  end

  assign vid_rvalid = vid_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign blt_rvalid = blt_rvalid_q;
  assign vid_rdata  = vid_rdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign blt_rdata  = blt_rdata_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural registered-read RAM.
module tb_vram_arbiter;

  localparam int unsigned AW = 15;

  logic          clk, reset_n;
  logic          vid_req, vid_ack, vid_rvalid;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_rdata;
  logic          cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          blt_req, blt_we, blt_ack, blt_rvalid;
  logic [AW-1:0] blt_addr;
  logic [7:0]    blt_wdata, blt_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din, ram_dout;
  logic [3:0]    starve_cnt;

  logic [7:0] mem [0:32767];
  int n_checks, n_errors, ph;

  vram_arbiter #(.AW(AW), .STARVE_MAX(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .blt_req(blt_req), .blt_we(blt_we), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
    .blt_ack(blt_ack), .blt_rvalid(blt_rvalid), .blt_rdata(blt_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM with read-before-write behaviour.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    ph ^= 1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic align0();
    while (ph != 0) next();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ph = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_acks"},   32'({vid_ack, cpu_ack, blt_ack}), 32'd0);
    chk({tag, "_rvalid"}, 32'({vid_rvalid, cpu_rvalid, blt_rvalid}), 32'd0);
    chk({tag, "_rdata"},  32'({vid_rdata, cpu_rdata, blt_rdata}), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_din"}, 32'(ram_din), 32'd0);
    chk({tag, "_starve"}, 32'(starve_cnt), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; ph = 0;
    reset_n = 1'b0;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    blt_req = 1'b0; blt_we = 1'b0; blt_addr = '0; blt_wdata = '0;
    for (int i = 0; i < 32768; i++) mem[15'(i)] = 8'(i * 7);
    mem[15'h0123] = 8'hA5;
    mem[15'h0040] = 8'h11;
    mem[15'h0005] = 8'h77;

    // Reset: a pending CPU request must not be acknowledged
    cpu_req = 1'b1; cpu_addr = 15'h0123;
    repeat (2) @(posedge clk);
    smp();
    chk_reset_vals("rst");

    // Idle-video CPU read
    release_rst();
    smp();
    chk("rd_ack", 32'(cpu_ack), 32'd1);
    chk("rd_addr", 32'(ram_addr), 32'h0123);
    chk("rd_we", 32'(ram_we), 32'd0);
    next(); cpu_req = 1'b0;
    smp();
    chk("rd_rv_n1", 32'(cpu_rvalid), 32'd0);
    chk("rd_addr_hold", 32'(ram_addr), 32'h0123);
    chk("rd_idle_we", 32'(ram_we), 32'd0);
    next(); smp();
    chk("rd_rv_n2", 32'(cpu_rvalid), 32'd1);
    chk("rd_data", 32'(cpu_rdata), 32'h00A5);
    next(); smp();
    chk("rd_rv_n3", 32'(cpu_rvalid), 32'd0);
    chk("rd_data_hold", 32'(cpu_rdata), 32'h00A5);

    // Video/CPU contention alternates by slot
    align0();
    vid_req = 1'b1; vid_addr = 15'h0010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0020;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next();
      smp();
      chk($sformatf("cont_vid%0d", i), 32'(vid_ack), 32'(i % 2 == 0));
      chk($sformatf("cont_cpu%0d", i), 32'(cpu_ack), 32'(i % 2 == 1));
    end
    next(); vid_req = 1'b0; cpu_req = 1'b0;
    repeat (3) next();

    // Starvation: blitter forced in the first shared slot once the count reaches 8
    align0();
    vid_req = 1'b1; vid_addr = 15'h0011;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0021;
    blt_req = 1'b1; blt_we = 1'b0; blt_addr = 15'h0030;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) next();
      if (i == 10) blt_req = 1'b0;
      smp();
      chk($sformatf("stv_vid%0d", i), 32'(vid_ack), 32'(i % 2 == 0));
      chk($sformatf("stv_cpu%0d", i), 32'(cpu_ack), 32'((i % 2 == 1) && (i != 9)));
      chk($sformatf("stv_blt%0d", i), 32'(blt_ack), 32'(i == 9));
      chk($sformatf("stv_cnt%0d", i), 32'(starve_cnt), (i <= 9) ? 32'(i) : 32'd0);
    end
    next(); vid_req = 1'b0; cpu_req = 1'b0;
    repeat (3) next();

    // Blitter write to the top address, then CPU read-back
    align0();
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 15'h7FFF; blt_wdata = 8'h3C;
    smp();
    chk("wr_ack", 32'(blt_ack), 32'd1);
    chk("wr_we", 32'(ram_we), 32'd1);
    chk("wr_addr", 32'(ram_addr), 32'h7FFF);
    chk("wr_din", 32'(ram_din), 32'h003C);
    next(); blt_req = 1'b0; blt_we = 1'b0;
    smp();
    chk("wr_we_off", 32'(ram_we), 32'd0);
    chk("wr_din_hold", 32'(ram_din), 32'h003C);
    next(); smp();
    chk("wr_no_rv", 32'(blt_rvalid), 32'd0);
    next(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h7FFF;
    smp();
    chk("wrb_ack", 32'(cpu_ack), 32'd1);
    next(); cpu_req = 1'b0;
    next(); smp();
    chk("wrb_rv", 32'(cpu_rvalid), 32'd1);
    chk("wrb_data", 32'(cpu_rdata), 32'h003C);

    // Read immediately followed by a write to the same address
    next(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0040;
    smp();
    chk("rw_rd_ack", 32'(cpu_ack), 32'd1);
    next(); cpu_req = 1'b0;
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 15'h0040; blt_wdata = 8'h99;
    smp();
    chk("rw_wr_ack", 32'(blt_ack), 32'd1);
    chk("rw_wr_we", 32'(ram_we), 32'd1);
    next(); blt_req = 1'b0; blt_we = 1'b0;
    smp();
    chk("rw_rv", 32'(cpu_rvalid), 32'd1);
    chk("rw_old_data", 32'(cpu_rdata), 32'h0011);
    next(); cpu_req = 1'b1; cpu_addr = 15'h0040;
    smp();
    chk("rw_rd2_ack", 32'(cpu_ack), 32'd1);
    next(); cpu_req = 1'b0;
    next(); smp();
    chk("rw_new_data", 32'(cpu_rdata), 32'h0099);

    // Same-address CPU and blitter writes are serialized, CPU first
    next(); if (ph != 1) next();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0050; cpu_wdata = 8'hAA;
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 15'h0050; blt_wdata = 8'hBB;
    smp();
    chk("ser_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("ser_blt_wait", 32'(blt_ack), 32'd0);
    chk("ser_din1", 32'(ram_din), 32'h00AA);
    next(); cpu_req = 1'b0; cpu_we = 1'b0;
    smp();
    chk("ser_blt_ack", 32'(blt_ack), 32'd1);
    chk("ser_din2", 32'(ram_din), 32'h00BB);
    next(); blt_req = 1'b0; blt_we = 1'b0;
    repeat (2) next();

    // Reset one cycle after a video read grant discards the read
    align0();
    vid_req = 1'b1; vid_addr = 15'h0005;
    smp();
    chk("mr_vid_ack", 32'(vid_ack), 32'd1);
    next(); vid_req = 1'b0; reset_n = 1'b0;
    smp();
    chk_reset_vals("mr");
    next(); smp();
    chk("mr_no_rv", 32'(vid_rvalid), 32'd0);
    release_rst();
    vid_req = 1'b1; vid_addr = 15'h0005;
    smp();
    chk("mr_resume_ack", 32'(vid_ack), 32'd1);
    next(); vid_req = 1'b0;
    smp();
    chk("mr_rv_n1", 32'(vid_rvalid), 32'd0);
    next(); smp();
    chk("mr_rv_n2", 32'(vid_rvalid), 32'd1);
    chk("mr_data", 32'(vid_rdata), 32'h0077);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 15, meaning the VRAM byte-address width (32 KB).
REQ-002 The module SHALL have parameter STARVE_MAX, default 8, meaning the number of consecutive lost arbitrations after which the blitter is forced a grant.
REQ-003 The module SHALL have one clock and one reset: clk in 1 (32 MHz pixel clock, sole clock) and reset_n in 1 (asynchronous, active-low).
REQ-004 The module SHALL have the video port: vid_req in 1; vid_addr in AW; vid_ack out 1; vid_rvalid out 1; vid_rdata out 8.
REQ-005 The module SHALL have the CPU port: cpu_req in 1; cpu_we in 1; cpu_addr in AW; cpu_wdata in 8; cpu_ack out 1; cpu_rvalid out 1; cpu_rdata out 8.
REQ-006 The module SHALL have the blitter port: blt_req in 1; blt_we in 1; blt_addr in AW; blt_wdata in 8; blt_ack out 1; blt_rvalid out 1; blt_rdata out 8.
REQ-007 The module SHALL have the RAM port: ram_addr out AW; ram_we out 1; ram_din out 8; ram_dout in 8 (registered read, valid the cycle after address).
REQ-008 The module SHALL have the status output starve_cnt out 4, the current blitter lost-arbitration count.

Function
REQ-009 A 1-bit slot phase SHALL toggle every clk: 0 is the video slot, 1 is the shared slot.
REQ-010 Arbitration SHALL be combinational from current requests and phase; exactly one grant or none per cycle.
REQ-011 Video slot (phase 0): vid_req wins; if vid_req=0, the slot falls to the shared-slot rule (REQ-012).
REQ-012 Shared rule, in priority order: blt forced (starve_cnt>=STARVE_MAX and blt_req); then cpu_req; then blt_req.
REQ-013 vid_req SHALL never be granted in phase 1.
REQ-014 The granted requester's *_ack SHALL be high for exactly the grant cycle.
REQ-015 In the grant cycle, ram_addr, ram_we and ram_din SHALL equal the winner's addr, we and wdata (video: we=0).
REQ-016 When no grant occurs, ram_we SHALL be 0 and ram_addr/ram_din SHALL hold their last values.
REQ-017 A requester SHALL hold req, addr, we and wdata stable until it sees ack; the arbiter is not required to handle violations.
REQ-018 A requester MAY keep req high after ack to issue back-to-back accesses; each ack consumes one access.
REQ-019 Read grant in cycle N: ram_dout SHALL be captured at end of N+1 into the owner's *_rdata, and *_rvalid SHALL pulse high during N+2.
REQ-020 Read-to-rvalid latency SHALL be fixed at 2 cycles.
REQ-021 Write grants SHALL produce no rvalid.
REQ-022 *_rdata SHALL hold until the owner's next rvalid.
REQ-023 starve_cnt SHALL increment (saturating at 15) in each cycle where blt_req=1 and blt is not granted.
REQ-024 starve_cnt SHALL clear on a blt grant and SHALL clear when blt_req=0.
REQ-025 When the forced blt grant takes a cycle cpu_req wanted, the CPU SHALL simply wait; the next eligible cycle grants CPU (starve_cnt now 0).
REQ-026 Simultaneous cpu and blt requests to the same address SHALL be serialized by REQ-012 with no merging.
REQ-027 A read followed immediately by a write to the same address SHALL return pre-write data.

Reset
REQ-028 While reset_n=0: phase=0; all ack/rvalid=0; all rdata=8'h00; ram_we=0; ram_addr=0; ram_din=0; starve_cnt=0; pipeline valid bits cleared.
REQ-029 After reset_n deasserts, the first clk edge SHALL begin phase 0 with normal arbitration.
REQ-030 Reset mid-read SHALL discard the pending rvalid; no rvalid SHALL appear after release.

Verification
REQ-031 Idle-video read: cpu read of addr 0x0123 (RAM holds 8'hA5) with vid_req=0 -> cpu_ack in first cycle; cpu_rvalid=1 with cpu_rdata=8'hA5 two cycles later.
REQ-032 Contention: vid_req and cpu_req held continuously -> vid_ack only in phase 0 and cpu_ack only in phase 1, alternating, never coincident.
REQ-033 Starvation: cpu_req and blt_req held continuously, vid_req=1, STARVE_MAX=8 -> blt_ack after 8 lost cycles; starve_cnt returns to 0; cpu_ack resumes next phase-1 slot.
REQ-034 Write: blt write 8'h3C to 0x7FFF (top address), then cpu read of 0x7FFF -> ram_we pulse with ram_addr=0x7FFF; cpu_rdata=8'h3C.
REQ-035 Reset mid-read: reset_n low one cycle after a vid read grant -> no vid_rvalid; all outputs at reset values; arbitration resumes in phase 0.
